btb_ras_pred: RTL and testbench
===============================

BTB_RAS_PRED -- requirements
Module: btb_ras_pred

Interface
REQ-001 SHALL have parameter BTB_NUM, default 32, number of fully-associative BTB entries (power of 2, 4..64).
REQ-002 SHALL have parameter RAS_DEPTH, default 8, number of return-address-stack entries (power of 2, 2..32).
REQ-003 SHALL have derived parameter IDX_W = clog2(BTB_NUM), BTB index width.
REQ-004 SHALL have clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have fetch_en  in  1  lookup request, and fetch_pc  in  32  lookup PC.
REQ-007 SHALL have pred_valid  out  1  lookup result valid.
REQ-008 SHALL have pred_taken  out  1  predicted taken, and pred_target  out  32  predicted next PC.
REQ-009 SHALL have pred_index  out  IDX_W  hit entry index, and pred_hit  out  1  BTB hit.
REQ-010 SHALL have upd_en  in  1  resolve-stage update strobe, and upd_pc  in  32  branch PC.
REQ-011 SHALL have upd_index  in  IDX_W  entry returned with the prediction, and upd_hit  in  1  prediction was a hit.
REQ-012 SHALL have upd_kind  in  2  branch type: 0 cond, 1 call, 2 return, 3 direct jump.
REQ-013 SHALL have upd_taken  in  1  resolved direction, and upd_target  in  32  resolved target.
REQ-014 SHALL have upd_del  in  1  invalidate entry upd_index (the PC is not a branch).
REQ-015 SHALL have ras_empty  out  1  and ras_full  out  1  RAS occupancy flags.

Function
REQ-016 SHALL store per entry: valid, pc[31:2], target[31:2], kind[1:0], 2-bit saturating counter.
REQ-017 SHALL register fetch_pc when fetch_en=1; pred_valid SHALL be 1 exactly one cycle after fetch_en=1, else 0.
REQ-018 SHALL evaluate the lookup in cycle N+1 against table state in cycle N+1, so an update written at edge N+1 is visible.
REQ-019 On miss: pred_hit=0, pred_taken=0, pred_target=fetch_pc_r+4, pred_index=0.
REQ-020 On hit: pred_hit=1, pred_index=matching entry; more than one match cannot occur (see REQ-025).
REQ-021 Hit kind cond: pred_taken=counter[1]; kind call/jump: pred_taken=1; pred_target=stored target when taken, else fetch_pc_r+4.
REQ-022 Hit kind return: pred_taken=1 and pred_target=RAS top when RAS non-empty; pred_taken=0 and pred_target=fetch_pc_r+4 when empty.
REQ-023 When pred_valid=0, pred_taken SHALL be 0.
REQ-024 Update with upd_en=1, upd_hit=1, upd_del=0: counter of upd_index increments if upd_taken, else decrements, saturating at 3 and 0; target is overwritten with upd_target when upd_taken=1; kind is overwritten with upd_kind.
REQ-025 Update with upd_hit=0 and upd_taken=1: if a valid entry already matches upd_pc, treat it as REQ-024 on that entry; otherwise allocate.
REQ-026 Allocation victim priority: lowest-index invalid entry; else lowest-index entry with counter=0; else round-robin pointer, which then increments modulo BTB_NUM.
REQ-027 A newly allocated entry SHALL have valid=1, counter=2'b10 for cond and 2'b11 for call/return/jump, pc, target and kind from the update.
REQ-028 upd_hit=0 with upd_taken=0 SHALL NOT allocate.
REQ-029 upd_del=1 with upd_en=1 SHALL clear valid of upd_index and take priority over any update of that entry in the same cycle.
REQ-030 RAS push on upd_en with kind call pushes upd_pc+4; pop on upd_en with kind return; the RAS is updated even when upd_del=1.
REQ-031 Push when full SHALL overwrite the oldest entry (circular buffer): the depth count stays RAS_DEPTH and the top becomes the new value.
REQ-032 Pop when empty SHALL be a no-op.
REQ-033 ras_empty = (count==0); ras_full = (count==RAS_DEPTH).

Reset
REQ-034 Reset SHALL clear all valid bits, counters, the round-robin pointer, RAS pointer and count, and pred_valid; all outputs SHALL be 0 except ras_empty=1.
REQ-035 Reset asserted during a pending lookup SHALL drop it: pred_valid=0 in the following cycle.

Verification
REQ-036 After reset, fetch 0x1000 -> next cycle: pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0x1004.
REQ-037 Update cond 0x1000 taken, target 0x2000, then fetch 0x1000 -> hit, taken, target 0x2000; two not-taken updates -> counter 0, predicts 0x1004.
REQ-038 With BTB_NUM=4, allocate 5 taken branches with no counter=0 entries -> 5th replaces entry 0, and the round-robin pointer becomes 1.
REQ-039 Nine call updates at PCs 0x100..0x120 with RAS_DEPTH=8 -> ras_full=1, the top is 0x124; eight pops -> ras_empty=1; a further pop is a no-op.
REQ-040 Return entry hit with empty RAS -> pred_taken=0; after call at 0x500 -> pred_target=0x504.
REQ-041 upd_del and an update of the same index in one cycle -> the entry is invalid and the next fetch misses.

Source files
------------

// File: rtl/btb_ras_pred.sv
// btb_ras_pred: fully-associative BTB with 2-bit counters and a circular return-address stack.
module btb_ras_pred #(
  parameter int BTB_NUM   = 32,
  parameter int RAS_DEPTH = 8,
  parameter int IDX_W     = $clog2(BTB_NUM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_en,
  input  logic [31:0]      fetch_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [IDX_W-1:0] pred_index,
  output logic             pred_hit,
  input  logic             upd_en,
  input  logic [31:0]      upd_pc,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_hit,
  input  logic [1:0]       upd_kind,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_del,
  output logic             ras_empty,
  output logic             ras_full
);
  localparam int RW = $clog2(RAS_DEPTH);
  logic [BTB_NUM-1:0] r_valid;
  logic [29:0]        r_pc   [BTB_NUM];
  logic [29:0]        r_tgt  [BTB_NUM];
  logic [1:0]         r_kind [BTB_NUM];
  logic [1:0]         r_ctr  [BTB_NUM];
  logic [IDX_W-1:0]   r_rr;
  logic [31:0]        r_ras  [RAS_DEPTH];
  logic [RW-1:0]      r_sp;
  logic [RW:0]        r_cnt;
  logic               r_fv;
  logic [31:0]        r_fpc;
  logic               w_hit, w_uany, w_inv_f, w_z_f, w_taken, w_upd, w_alloc, w_miss_t;
  logic [IDX_W-1:0]   w_hidx, w_umidx, w_inv_i, w_z_i, w_uidx, w_vidx;
  logic [1:0]         w_kind, w_c, w_cnext;
  logic [31:0]        w_pc4, w_ras_top;
  logic               w_unused;
  assign w_unused = ^upd_target[1:0];
  // Scan high to low so the last assignment leaves the lowest matching index.
  always_comb begin
    w_hit   = 1'b0;
    w_hidx  = '0;
    w_uany  = 1'b0;
    w_umidx = '0;
    w_inv_f = 1'b0;
    w_inv_i = '0;
    w_z_f   = 1'b0;
    w_z_i   = '0;
    for (int i = BTB_NUM - 1; i >= 0; i--) begin
      if (r_valid[i] && r_pc[i] == r_fpc[31:2]) begin
        w_hit  = 1'b1;
        w_hidx = IDX_W'(i);
      end
      if (r_valid[i] && r_pc[i] == upd_pc[31:2]) begin
        w_uany  = 1'b1;
        w_umidx = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_inv_f = 1'b1;
        w_inv_i = IDX_W'(i);
      end
      if (r_valid[i] && r_ctr[i] == 2'd0) begin
        w_z_f = 1'b1;
        w_z_i = IDX_W'(i);
      end
    end
  end
  assign ras_empty   = r_cnt == '0;
  assign ras_full    = r_cnt == (RW+1)'(RAS_DEPTH);
  assign w_ras_top   = r_ras[r_sp - 1'b1];
  assign w_pc4       = r_fpc + 32'd4;
  assign w_kind      = r_kind[w_hidx];
  assign w_taken     = w_hit && (w_kind == 2'd0 ? r_ctr[w_hidx][1] : w_kind == 2'd2 ? !ras_empty : 1'b1);
  assign pred_valid  = r_fv;
  assign pred_hit    = r_fv && w_hit;
  assign pred_taken  = r_fv && w_taken;
  assign pred_index  = r_fv ? w_hidx : '0;
  assign pred_target = !r_fv ? 32'd0 : !w_taken ? w_pc4 : w_kind == 2'd2 ? w_ras_top : {r_tgt[w_hidx], 2'b00};
  assign w_miss_t    = upd_en && !upd_hit && upd_taken;
  assign w_upd       = (upd_en && upd_hit && !upd_del) || (w_miss_t && w_uany);
  assign w_alloc     = w_miss_t && !w_uany;
  assign w_uidx      = upd_hit ? upd_index : w_umidx;
  assign w_vidx      = w_inv_f ? w_inv_i : w_z_f ? w_z_i : r_rr;
  assign w_c         = r_ctr[w_uidx];
  assign w_cnext     = upd_taken ? (w_c == 2'd3 ? w_c : w_c + 2'd1) : (w_c == 2'd0 ? w_c : w_c - 2'd1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fv    <= 1'b0;
      r_valid <= '0;
      r_rr    <= '0;
      r_sp    <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < BTB_NUM; i++) r_ctr[i] <= 2'd0;
    end else begin
      r_fv <= fetch_en;
      if (fetch_en) r_fpc <= fetch_pc;
      if (w_upd) begin
        r_ctr[w_uidx]  <= w_cnext;
        r_kind[w_uidx] <= upd_kind;
        if (upd_taken) r_tgt[w_uidx] <= upd_target[31:2];
      end
      if (w_alloc) begin
        r_valid[w_vidx] <= 1'b1;
        r_ctr[w_vidx]   <= upd_kind == 2'd0 ? 2'b10 : 2'b11;
        r_pc[w_vidx]    <= upd_pc[31:2];
        r_tgt[w_vidx]   <= upd_target[31:2];
        r_kind[w_vidx]  <= upd_kind;
        if (!w_inv_f && !w_z_f) r_rr <= r_rr + 1'b1;
      end
      // Delete is applied last so it wins over any same-cycle write to that entry.
      if (upd_en && upd_del) r_valid[upd_index] <= 1'b0;
      if (upd_en && upd_kind == 2'd1) begin
        r_ras[r_sp] <= upd_pc + 32'd4;
        r_sp        <= r_sp + 1'b1;
        if (!ras_full) r_cnt <= r_cnt + 1'b1;
      end else if (upd_en && upd_kind == 2'd2 && !ras_empty) begin
        r_sp  <= r_sp - 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_btb_ras_pred.sv
// tb_btb_ras_pred: directed scoreboard bench for btb_ras_pred (4-entry BTB, 8-deep RAS).
module tb_btb_ras_pred;
  localparam int BN = 4;
  localparam int RD = 8;
  localparam int IW = 2;
  logic          clk = 1'b0;
  logic          reset, fetch_en, upd_en, upd_hit, upd_taken, upd_del;
  logic [31:0]   fetch_pc, upd_pc, upd_target, pred_target;
  logic [IW-1:0] upd_index, pred_index;
  logic [1:0]    upd_kind;
  logic          pred_valid, pred_taken, pred_hit, ras_empty, ras_full;
  typedef struct {
    logic          hit;
    logic          taken;
    logic [31:0]   tgt;
    logic [IW-1:0] idx;
    int            id;
  } exp_t;
  exp_t q[$];
  exp_t m_e;
  int checks = 0;
  int errors = 0;
  int nfetch = 0;
  btb_ras_pred #(.BTB_NUM(BN), .RAS_DEPTH(RD)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_index(pred_index), .pred_hit(pred_hit), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_index(upd_index), .upd_hit(upd_hit), .upd_kind(upd_kind), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_del(upd_del), .ras_empty(ras_empty), .ras_full(ras_full)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (pred_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pred: pred_valid=1 with no lookup pending (target %h)", pred_target);
      end else begin
        m_e = q.pop_front();
        chk($sformatf("f%0d_hit", m_e.id), {31'd0, pred_hit}, {31'd0, m_e.hit});
        chk($sformatf("f%0d_taken", m_e.id), {31'd0, pred_taken}, {31'd0, m_e.taken});
        chk($sformatf("f%0d_target", m_e.id), pred_target, m_e.tgt);
        chk($sformatf("f%0d_index", m_e.id), {30'd0, pred_index}, {30'd0, m_e.idx});
      end
    end else if (pred_valid === 1'b0) begin
      chk("taken_while_invalid", {31'd0, pred_taken}, 32'd0);
    end
  end
  task automatic fetch(input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tg, input logic [IW-1:0] ix);
    exp_t e;
    e.hit = h; e.taken = t; e.tgt = tg; e.idx = ix; e.id = nfetch++;
    q.push_back(e);
    fetch_en = 1'b1;
    fetch_pc = pc;
    @(posedge clk); #1;
    fetch_en = 1'b0;
  endtask
  task automatic upd(input logic [31:0] pc, input logic [IW-1:0] ix, input logic h, input logic [1:0] k,
                     input logic t, input logic [31:0] tg, input logic d);
    upd_en = 1'b1; upd_pc = pc; upd_index = ix; upd_hit = h; upd_kind = k;
    upd_taken = t; upd_target = tg; upd_del = d;
    @(posedge clk); #1;
    upd_en = 1'b0; upd_del = 1'b0;
  endtask
  initial begin
    reset = 1'b1; fetch_en = 1'b0; fetch_pc = '0; upd_en = 1'b0; upd_pc = '0; upd_index = '0;
    upd_hit = 1'b0; upd_kind = '0; upd_taken = 1'b0; upd_target = '0; upd_del = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, pred_valid}, 32'd0);
    chk("rst_hit", {31'd0, pred_hit}, 32'd0);
    chk("rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_target", pred_target, 32'd0);
    chk("rst_index", {30'd0, pred_index}, 32'd0);
    chk("rst_empty", {31'd0, ras_empty}, 32'd1);
    chk("rst_full", {31'd0, ras_full}, 32'd0);
    reset = 1'b0;
    fetch(32'h1000, 0, 0, 32'h1004, 0);
    upd(32'h1000, 0, 0, 2'd0, 1, 32'h2000, 0);
    fetch(32'h1000, 1, 1, 32'h2000, 0);
    upd(32'h1000, 0, 1, 2'd0, 0, 32'h0, 0);
    upd(32'h1000, 0, 1, 2'd0, 0, 32'h0, 0);
    fetch(32'h1000, 1, 0, 32'h1004, 0);
    upd(32'h1000, 0, 0, 2'd0, 1, 32'h2400, 0);
    fetch(32'h1000, 1, 0, 32'h1004, 0);
    upd(32'h1000, 0, 1, 2'd0, 1, 32'h2400, 0);
    fetch(32'h1000, 1, 1, 32'h2400, 0);
    upd(32'h3000, 0, 0, 2'd0, 0, 32'h9000, 0);
    fetch(32'h3000, 0, 0, 32'h3004, 0);
    upd(32'h1100, 0, 0, 2'd3, 1, 32'h1200, 0);
    upd(32'h1104, 0, 0, 2'd0, 1, 32'h1300, 0);
    upd(32'h1108, 0, 0, 2'd3, 1, 32'h1400, 0);
    upd(32'h1110, 0, 0, 2'd0, 1, 32'h1500, 0);
    fetch(32'h1110, 1, 1, 32'h1500, 0);
    fetch(32'h1000, 0, 0, 32'h1004, 0);
    upd(32'h1114, 0, 0, 2'd3, 1, 32'h1600, 0);
    fetch(32'h1114, 1, 1, 32'h1600, 1);
    fetch(32'h1100, 0, 0, 32'h1104, 0);
    fetch(32'h1104, 1, 1, 32'h1300, 2);
    upd(32'h1104, 2, 1, 2'd0, 0, 32'h0, 0);
    upd(32'h1104, 2, 1, 2'd0, 0, 32'h0, 0);
    fetch(32'h1104, 1, 0, 32'h1108, 2);
    upd(32'h1118, 0, 0, 2'd0, 1, 32'h1700, 0);
    fetch(32'h1118, 1, 1, 32'h1700, 2);
    upd(32'h1108, 3, 1, 2'd3, 1, 32'h1900, 1);
    fetch(32'h1108, 0, 0, 32'h110C, 0);
    upd(32'h111C, 0, 0, 2'd3, 1, 32'h1A00, 0);
    fetch(32'h111C, 1, 1, 32'h1A00, 3);
    upd(32'h600, 0, 0, 2'd2, 1, 32'h0, 0);
    chk("ras_empty_a", {31'd0, ras_empty}, 32'd1);
    fetch(32'h600, 1, 0, 32'h604, 2);
    upd(32'h500, 0, 0, 2'd1, 0, 32'h0, 0);
    chk("ras_empty_b", {31'd0, ras_empty}, 32'd0);
    fetch(32'h600, 1, 1, 32'h504, 2);
    upd(32'h700, 0, 0, 2'd2, 0, 32'h0, 0);
    chk("ras_empty_c", {31'd0, ras_empty}, 32'd1);
    for (int k = 0; k < 9; k++) begin
      upd(32'h100 + 32'(4 * k), 0, 0, 2'd1, 0, 32'h0, 0);
      if (k >= 6) chk($sformatf("ras_full_%0d", k), {31'd0, ras_full}, (k >= 7) ? 32'd1 : 32'd0);
    end
    fetch(32'h600, 1, 1, 32'h124, 2);
    upd(32'h700, 0, 0, 2'd2, 0, 32'h0, 0);
    chk("ras_full_after_pop", {31'd0, ras_full}, 32'd0);
    fetch(32'h600, 1, 1, 32'h120, 2);
    for (int k = 0; k < 6; k++) upd(32'h700, 0, 0, 2'd2, 0, 32'h0, 0);
    fetch(32'h600, 1, 1, 32'h108, 2);
    upd(32'h700, 0, 0, 2'd2, 0, 32'h0, 0);
    chk("ras_empty_d", {31'd0, ras_empty}, 32'd1);
    fetch(32'h600, 1, 0, 32'h604, 2);
    upd(32'h700, 0, 0, 2'd2, 0, 32'h0, 0);
    chk("ras_empty_e", {31'd0, ras_empty}, 32'd1);
    chk("ras_full_e", {31'd0, ras_full}, 32'd0);
    upd(32'h700, 0, 0, 2'd1, 0, 32'h0, 0);
    chk("ras_empty_f", {31'd0, ras_empty}, 32'd0);
    fetch(32'h600, 1, 1, 32'h704, 2);
    repeat (2) @(posedge clk);
    #1;
    fetch_en = 1'b1;
    fetch_pc = 32'h1110;
    reset    = 1'b1;
    @(posedge clk); #1;
    fetch_en = 1'b0;
    reset    = 1'b0;
    chk("reset_drops_pred", {31'd0, pred_valid}, 32'd0);
    chk("reset_ras_empty", {31'd0, ras_empty}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_preds: %0d predictions never presented, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
